// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding plus ACK and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Strobe interface between the I2C register target and an external register bank.
// Handshake: reg_wr_en / reg_rd_en are single-clk strobes with no back-pressure; reg_addr
// and reg_wr_data are valid with the strobe, and reg_rd_data must be valid on the clk after reg_rd_en.
interface i2c_reg_target_if #(
  parameter int AW = 4
);
  logic          reg_wr_en;
  logic          reg_rd_en;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wr_data;
  logic [7:0]    reg_rd_data;

  modport master (
    output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
    input  reg_rd_data
  );

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
    output reg_rd_data
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA pads and derives SCL edges plus START/STOP bus conditions.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_sync,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_last;
  logic                   sda_last;
  logic                   scl_s;
  logic                   sda_s;

  // Preset to 1 so an idle (pulled-up) bus produces no edges out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_last   <= 1'b1;
      sda_last   <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_last   <= scl_s;
      sda_last   <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign sda_sync = sda_s;
  assign scl_rise = scl_s & ~scl_last;
  assign scl_fall = ~scl_s & scl_last;
  assign start    = scl_s & scl_last & sda_last & ~sda_s;
  assign stop     = scl_s & scl_last & ~sda_last & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C register-access target: address match, pointer byte, auto-incrementing
// multi-byte writes/reads, repeated START, driving an external register bank.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h69,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               sda_oe,
  i2c_reg_target_if.master   reg_bus,
  output logic               busy,
  output logic               start_det,
  output logic               stop_det,
  output i2c_state_t         dbg_state
);

  localparam int AW = (NUM_REGS <= 2) ? 1 : $clog2(NUM_REGS);

  logic scl_rise, scl_fall, sda_sync, start, stop;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_sync (sda_sync),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_t    state, state_n;
  logic [7:0]    sh, sh_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          byte_done, byte_done_n;
  logic [AW-1:0] ptr, ptr_n, ptr_inc;
  logic          sda_oe_n, busy_n;
  logic          wr_en, wr_en_n, rd_en, rd_en_n, rd_en_q;
  logic [AW-1:0] addr_q, addr_n;
  logic [7:0]    wdata_q, wdata_n;

  assign ptr_inc = (ptr == AW'(NUM_REGS - 1)) ? '0 : ptr + AW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      sh        <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      bit_cnt   <= bit_cnt_n;
      byte_done <= byte_done_n;
      ptr       <= ptr_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_en     <= wr_en_n;
      rd_en     <= rd_en_n;
      rd_en_q   <= rd_en;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    sh_n        = sh;
    bit_cnt_n   = bit_cnt;
    byte_done_n = byte_done;
    ptr_n       = ptr;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    wr_en_n     = 1'b0;
    rd_en_n     = 1'b0;
    addr_n      = addr_q;
    wdata_n     = wdata_q;

    if (stop) begin
      state_n     = ST_IDLE;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
      bit_cnt_n   = '0;
      byte_done_n = 1'b0;
    end else if (start) begin
      state_n     = ST_ADDR;
      sda_oe_n    = 1'b0;
      bit_cnt_n   = '0;
      byte_done_n = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && !byte_done) begin
            sh_n        = {sh[6:0], sda_sync};
            bit_cnt_n   = bit_cnt + 3'd1;
            byte_done_n = (bit_cnt == 3'd7);
          end else if (scl_fall && byte_done) begin
            // Byte is complete; act on it as SCL drops into the ACK clock.
            byte_done_n = 1'b0;
            if (state == ST_ADDR) begin
              if (sh[7:1] == ADDRESS) begin
                sda_oe_n = 1'b1;
                busy_n   = 1'b1;
                state_n  = ST_ADDR_ACK;
              end else begin
                state_n  = ST_WAIT_STOP;
              end
            end else if (state == ST_PTR) begin
              if ({1'b0, sh} < 9'(NUM_REGS)) begin
                ptr_n    = sh[AW-1:0];
                sda_oe_n = 1'b1;
                state_n  = ST_PTR_ACK;
              end else begin
                state_n  = ST_WAIT_STOP;
              end
            end else begin
              wr_en_n  = 1'b1;
              addr_n   = ptr;
              wdata_n  = sh;
              ptr_n    = ptr_inc;
              sda_oe_n = 1'b1;
              state_n  = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            if (sh[0] == I2C_READ) begin
              rd_en_n = 1'b1;
              addr_n  = ptr;
              state_n = ST_RDATA;
            end else begin
              state_n = ST_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = ST_WDATA;
          end
        end
        ST_RDATA: begin
          // Bank data lands two clks after the fall that issued the read; SCL is still low then.
          if (rd_en_q) begin
            sh_n      = reg_bus.reg_rd_data;
            bit_cnt_n = '0;
            sda_oe_n  = ~reg_bus.reg_rd_data[7];
          end else if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n  = 1'b0;
              ptr_n     = ptr_inc;
              bit_cnt_n = '0;
              state_n   = ST_RDATA_ACK;
            end else begin
              sh_n      = {sh[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 3'd1;
              sda_oe_n  = ~sh[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && sda_sync == I2C_NACK) begin
            state_n = ST_WAIT_STOP;
          end else if (scl_fall) begin
            rd_en_n = 1'b1;
            addr_n  = ptr;
            state_n = ST_RDATA;
          end
        end
        ST_WAIT_STOP: sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign reg_bus.reg_wr_en   = wr_en;
  assign reg_bus.reg_rd_en   = rd_en;
  assign reg_bus.reg_addr    = addr_q;
  assign reg_bus.reg_wr_data = wdata_q;
  assign start_det           = start;
  assign stop_det            = stop;
  assign dbg_state           = state;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged I2C master, register bank model, strobe scoreboard.
module tb_i2c_reg_target;
  import i2c_pkg::*;

  localparam int Q = 6;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_i = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe;
  logic       busy, start_det, stop_det;
  i2c_state_t dbg_state;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int stop_cnt = 0;

  logic [7:0]  mem [16];
  logic [11:0] exp_q[$];
  logic [3:0]  exp_rd_q[$];

  i2c_reg_target_if #(.AW(4)) reg_bus ();

  assign sda_i = sda_m & ~sda_oe;

  i2c_reg_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .reg_bus   (reg_bus.master),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run did not finish within 60000 clks");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // register bank model
  always @(posedge clk)
    if (reg_bus.reg_rd_en) reg_bus.reg_rd_data <= mem[reg_bus.reg_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard on strobes and bus-condition pulses
  always @(negedge clk) begin
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (reg_bus.reg_wr_en || reg_bus.reg_rd_en)
      check("wr_rd_exclusive", {31'd0, reg_bus.reg_wr_en & reg_bus.reg_rd_en}, 32'd0);
    if (reg_bus.reg_wr_en)
      check("wr_strobe", {20'd0, reg_bus.reg_addr, reg_bus.reg_wr_data},
            (exp_q.size() > 0) ? {20'd0, exp_q.pop_front()} : 32'hdead);
    if (reg_bus.reg_rd_en)
      check("rd_strobe", {28'd0, reg_bus.reg_addr},
            (exp_rd_q.size() > 0) ? {28'd0, exp_rd_q.pop_front()} : 32'hdead);
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_clk(Q);
    scl_i = 1'b1; wait_clk(H);
    scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_i = 1'b1; wait_clk(H / 2);
    b = sda_i; wait_clk(H / 2);
    scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wait_clk(Q);
    scl_i = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wait_clk(Q);
    scl_i = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(mack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    bit         seen;
    int         s0;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    reg_bus.reg_rd_data = 8'h00;

    // reset state
    wait_clk(4);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_en", {31'd0, reg_bus.reg_wr_en}, 32'd0);
    check("rst_rd_en", {31'd0, reg_bus.reg_rd_en}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    wait_clk(10);

    // write ptr 5, data A5, 3C
    exp_q.push_back({4'h5, 8'hA5});
    exp_q.push_back({4'h6, 8'h3C});
    start_cond();
    check("t1_start_det", start_cnt, 1);
    send_byte(8'hD2, ack); check("t1_addr_ack", {31'd0, ack}, 32'd0);
    check("t1_busy_on", {31'd0, busy}, 32'd1);
    send_byte(8'h05, ack); check("t1_ptr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'hA5, ack); check("t1_d0_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h3C, ack); check("t1_d1_ack", {31'd0, ack}, 32'd0);
    stop_cond();
    check("t1_stop_det", stop_cnt, 1);
    check("t1_busy_off", {31'd0, busy}, 32'd0);
    check("t1_wr_all", exp_q.size(), 0);

    // wrong address: no ACKs, no strobes
    start_cond();
    send_byte(8'h24, ack); check("t2_addr_nack", {31'd0, ack}, 32'd1);
    check("t2_state", 32'(dbg_state), 32'(ST_WAIT_STOP));
    send_byte(8'h11, ack); check("t2_d0_nack", {31'd0, ack}, 32'd1);
    send_byte(8'h22, ack); check("t2_d1_nack", {31'd0, ack}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    stop_cond();

    // ptr 0x0F, repeated START, read two bytes with wrap
    mem[15] = 8'h11; mem[0] = 8'h22;
    exp_rd_q.push_back(4'hF);
    exp_rd_q.push_back(4'h0);
    s0 = start_cnt;
    start_cond();
    send_byte(8'hD2, ack); check("t3_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h0F, ack); check("t3_ptr_ack", {31'd0, ack}, 32'd0);
    start_cond();
    check("t3_busy_rs", {31'd0, busy}, 32'd1);
    send_byte(8'hD3, ack); check("t3_raddr_ack", {31'd0, ack}, 32'd0);
    recv_byte(d, I2C_ACK);  check("t3_rd0", {24'd0, d}, 32'h11);
    recv_byte(d, I2C_NACK); check("t3_rd1", {24'd0, d}, 32'h22);
    stop_cond();
    check("t3_start_det2", start_cnt - s0, 2);
    check("t3_rd_all", exp_rd_q.size(), 0);

    // out-of-range pointer: NACK, no write, pointer stays at 1
    start_cond();
    send_byte(8'hD2, ack); check("t4_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h20, ack); check("t4_ptr_nack", {31'd0, ack}, 32'd1);
    send_byte(8'h77, ack); check("t4_d_nack", {31'd0, ack}, 32'd1);
    stop_cond();
    mem[1] = 8'h5A;
    exp_rd_q.push_back(4'h1);
    start_cond();
    send_byte(8'hD3, ack); check("t4_raddr_ack", {31'd0, ack}, 32'd0);
    recv_byte(d, I2C_NACK); check("t4_ptr_kept", {24'd0, d}, 32'h5A);
    stop_cond();

    // STOP after 5 bits of a data byte, then a normal write
    start_cond();
    send_byte(8'hD2, ack);
    send_byte(8'h03, ack); check("t5_ptr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    stop_cond();
    check("t5_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_busy_off", {31'd0, busy}, 32'd0);
    exp_q.push_back({4'h8, 8'h99});
    start_cond();
    send_byte(8'hD2, ack); check("t5_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h08, ack);
    send_byte(8'h99, ack); check("t5_d_ack", {31'd0, ack}, 32'd0);
    stop_cond();
    check("t5_wr_all", exp_q.size(), 0);

    // reset while driving a 0 read bit
    mem[2] = 8'h0F;
    exp_rd_q.push_back(4'h2);
    start_cond();
    send_byte(8'hD2, ack);
    send_byte(8'h02, ack); check("t6_ptr_ack", {31'd0, ack}, 32'd0);
    start_cond();
    send_byte(8'hD3, ack); check("t6_raddr_ack", {31'd0, ack}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sda_oe) seen = 1'b1;
    end
    check("t6_driving", {31'd0, seen}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("t6_async_release", {31'd0, sda_oe}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    scl_i = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(10);
    mem[0] = 8'h22;
    exp_rd_q.push_back(4'h0);
    start_cond();
    send_byte(8'hD3, ack); check("t6_post_addr_ack", {31'd0, ack}, 32'd0);
    recv_byte(d, I2C_NACK); check("t6_ptr_zero", {24'd0, d}, 32'h22);
    stop_cond();
    wait_clk(10);
    check("end_rd_all", exp_rd_q.size(), 0);
    check("end_wr_all", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
